// File: rtl/cpu7_ifu_iq_pkg.sv
// rtl/cpu7_ifu_iq_pkg.sv - shared widths and entry field layout for the instruction queue
package cpu7_ifu_iq_pkg;

    localparam int LSOC1K_DECODE_RES_BIT = 48;
    localparam int IQ_GRLEN              = 32;

    // Entry layout, LSB first: exccode[5:0], exception, op, inst[31:0], pc
    localparam int IQ_EXCCODE_LSB = 0;
    localparam int IQ_EXC_BIT     = 6;
    localparam int IQ_OP_LSB      = 7;

    function automatic int iq_inst_lsb(input int op_w);
        return IQ_OP_LSB + op_w;
    endfunction

    function automatic int iq_pc_lsb(input int op_w);
        return IQ_OP_LSB + op_w + 32;
    endfunction

    function automatic int iq_entry_w(input int grlen, input int op_w);
        return iq_pc_lsb(op_w) + grlen;
    endfunction

    localparam int IQ_ENTRY_W = iq_entry_w(IQ_GRLEN, LSOC1K_DECODE_RES_BIT);

endpackage

// File: rtl/cpu7_iq_fifo_ram.sv
// rtl/cpu7_iq_fifo_ram.sv - entry storage: one synchronous write port, one async read port
module cpu7_iq_fifo_ram
    import cpu7_ifu_iq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = IQ_ENTRY_W,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Payload is deliberately not reset; the head is masked by the control logic instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu7_ifu_iq.sv
// rtl/cpu7_ifu_iq.sv - decoded-instruction queue feeding the EXU D-stage, flushable on redirect
module cpu7_ifu_iq
    import cpu7_ifu_iq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GRLEN = IQ_GRLEN,
    parameter int OP_W  = LSOC1K_DECODE_RES_BIT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dec_iq_valid,
    input  logic [GRLEN-1:0]             dec_iq_pc,
    input  logic [31:0]                  dec_iq_inst,
    input  logic [OP_W-1:0]              dec_iq_op,
    input  logic                         dec_iq_exception,
    input  logic [5:0]                   dec_iq_exccode,
    output logic                         iq_dec_ready,
    output logic                         ifu_exu_valid_d,
    output logic [GRLEN-1:0]             ifu_exu_pc_d,
    output logic [31:0]                  ifu_exu_inst_d,
    output logic [OP_W-1:0]              ifu_exu_op_d,
    output logic                         ifu_exu_exception_d,
    output logic [5:0]                   ifu_exu_exccode_d,
    input  logic                         exu_ifu_stall_req,
    input  logic                         iq_flush,
    output logic [$clog2(DEPTH+1)-1:0]   iq_count
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int ENT_W    = iq_entry_w(GRLEN, OP_W);
    localparam int INST_LSB = iq_inst_lsb(OP_W);
    localparam int PC_LSB   = iq_pc_lsb(OP_W);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] rd_entry;
    logic [ENT_W-1:0] head_entry;

    // Ready looks only at stored occupancy, so a full queue refuses even when popping.
    assign iq_dec_ready = (count != CNT_W'(DEPTH));
    assign head_valid   = (count != '0);
    assign push         = dec_iq_valid & iq_dec_ready & ~iq_flush;
    assign pop          = head_valid & ~exu_ifu_stall_req & ~iq_flush;

    assign wr_entry = {dec_iq_pc, dec_iq_inst, dec_iq_op, dec_iq_exception, dec_iq_exccode};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (iq_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    cpu7_iq_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Zero the head when empty so checkers never see stale storage.
    assign head_entry = head_valid ? rd_entry : '0;

    assign ifu_exu_valid_d     = head_valid;
    assign ifu_exu_pc_d        = head_entry[PC_LSB +: GRLEN];
    assign ifu_exu_inst_d      = head_entry[INST_LSB +: 32];
    assign ifu_exu_op_d        = head_entry[IQ_OP_LSB +: OP_W];
    assign ifu_exu_exception_d = head_entry[IQ_EXC_BIT];
    assign ifu_exu_exccode_d   = head_entry[IQ_EXCCODE_LSB +: 6];
    assign iq_count            = count;

    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && count == CNT_W'(DEPTH)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && count == '0));
    a_count_range:  assert property (@(posedge clk) disable iff (reset) count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_cpu7_ifu_iq.sv
// tb/tb_cpu7_ifu_iq.sv - randomized and directed bench for cpu7_ifu_iq against a queue model
module tb_cpu7_ifu_iq;
    import cpu7_ifu_iq_pkg::*;

    localparam int DEPTH = 4;
    localparam int GRLEN = IQ_GRLEN;
    localparam int OP_W  = LSOC1K_DECODE_RES_BIT;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [GRLEN-1:0] pc;
        logic [31:0]      inst;
        logic [OP_W-1:0]  op;
        logic             exc;
        logic [5:0]       code;
    } ent_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             dec_iq_valid;
    logic [GRLEN-1:0] dec_iq_pc;
    logic [31:0]      dec_iq_inst;
    logic [OP_W-1:0]  dec_iq_op;
    logic             dec_iq_exception;
    logic [5:0]       dec_iq_exccode;
    logic             iq_dec_ready;
    logic             ifu_exu_valid_d;
    logic [GRLEN-1:0] ifu_exu_pc_d;
    logic [31:0]      ifu_exu_inst_d;
    logic [OP_W-1:0]  ifu_exu_op_d;
    logic             ifu_exu_exception_d;
    logic [5:0]       ifu_exu_exccode_d;
    logic             exu_ifu_stall_req;
    logic             iq_flush;
    logic [CNT_W-1:0] iq_count;

    ent_t mq[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    cpu7_ifu_iq #(
        .DEPTH (DEPTH),
        .GRLEN (GRLEN),
        .OP_W  (OP_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .dec_iq_valid        (dec_iq_valid),
        .dec_iq_pc           (dec_iq_pc),
        .dec_iq_inst         (dec_iq_inst),
        .dec_iq_op           (dec_iq_op),
        .dec_iq_exception    (dec_iq_exception),
        .dec_iq_exccode      (dec_iq_exccode),
        .iq_dec_ready        (iq_dec_ready),
        .ifu_exu_valid_d     (ifu_exu_valid_d),
        .ifu_exu_pc_d        (ifu_exu_pc_d),
        .ifu_exu_inst_d      (ifu_exu_inst_d),
        .ifu_exu_op_d        (ifu_exu_op_d),
        .ifu_exu_exception_d (ifu_exu_exception_d),
        .ifu_exu_exccode_d   (ifu_exu_exccode_d),
        .exu_ifu_stall_req   (exu_ifu_stall_req),
        .iq_flush            (iq_flush),
        .iq_count            (iq_count)
    );

    function automatic ent_t exp_head();
        if (mq.size() == 0) return '0;
        return mq[0];
    endfunction

    function automatic ent_t dut_head();
        return {ifu_exu_pc_d, ifu_exu_inst_d, ifu_exu_op_d, ifu_exu_exception_d, ifu_exu_exccode_d};
    endfunction

    task automatic drive(input logic v, input logic [GRLEN-1:0] pc, input logic st, input logic fl,
                         input logic ex = 1'b0, input logic [5:0] cd = 6'h0);
        dec_iq_valid      = v;
        dec_iq_pc         = pc;
        dec_iq_inst       = $urandom;
        dec_iq_op         = OP_W'({$urandom, $urandom});
        dec_iq_exception  = ex;
        dec_iq_exccode    = cd;
        exu_ifu_stall_req = st;
        iq_flush          = fl;
    endtask

    // Reference: a plain FIFO of capacity DEPTH; acceptance depends only on the occupancy before the edge.
    task automatic tick();
        bit   acc;
        bit   take;
        ent_t e;
        acc  = dec_iq_valid && (mq.size() != DEPTH) && !iq_flush;
        take = (mq.size() != 0) && !exu_ifu_stall_req && !iq_flush;
        e    = '{dec_iq_pc, dec_iq_inst, dec_iq_op, dec_iq_exception, dec_iq_exccode};
        if (iq_flush) begin
            mq.delete();
        end else begin
            if (take) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (iq_dec_ready !== 1'b1 || ifu_exu_valid_d !== 1'b0 || iq_count !== '0)
            $display("FAIL reset_ctrl ready=%0b valid=%0b count=%0d exp 1/0/0", iq_dec_ready, ifu_exu_valid_d, iq_count);
        else passes++;
        checks++;
        if (dut_head() !== '0) $display("FAIL reset_head got %h exp 0", dut_head());
        else passes++;
        reset = 1'b0;
        mq.delete();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1c000000 + 32'(4 * i), 1'b1, 1'b0);
            tick();
        end
        checks++;
        if (iq_count !== CNT_W'(4) || iq_dec_ready !== 1'b0)
            $display("FAIL fill_full count=%0d ready=%0b exp 4/0", iq_count, iq_dec_ready);
        else passes++;
        drive(1'b1, 32'h1c000010, 1'b1, 1'b0);
        tick();
        checks++;
        if (iq_count !== CNT_W'(4)) $display("FAIL fill_refuse5 count=%0d exp 4", iq_count);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (ifu_exu_valid_d !== 1'b1 || ifu_exu_pc_d !== 32'h1c000000 + 32'(4 * i) || dut_head() !== exp_head())
                $display("FAIL drain_order[%0d] valid=%0b pc=%h exp pc %h", i, ifu_exu_valid_d, ifu_exu_pc_d,
                         32'h1c000000 + 32'(4 * i));
            else passes++;
            tick();
        end
        checks++;
        if (ifu_exu_valid_d !== 1'b0 || dut_head() !== '0 || iq_count !== '0)
            $display("FAIL drain_empty valid=%0b head=%h count=%0d exp 0", ifu_exu_valid_d, dut_head(), iq_count);
        else passes++;
    endtask

    task automatic test_latency();
        drive(1'b1, 32'h100, 1'b1, 1'b0);
        checks++;
        if (ifu_exu_valid_d !== 1'b0) $display("FAIL latency_same_cycle valid=%0b exp 0", ifu_exu_valid_d);
        else passes++;
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (ifu_exu_valid_d !== 1'b1 || ifu_exu_pc_d !== 32'h100)
            $display("FAIL latency_next valid=%0b pc=%h exp 1/100", ifu_exu_valid_d, ifu_exu_pc_d);
        else passes++;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h308 + 32'(4 * i), 1'b0, 1'b0);
            checks++;
            if (iq_count !== CNT_W'(2) || ifu_exu_pc_d !== 32'h300 + 32'(4 * i) || dut_head() !== exp_head())
                $display("FAIL b2b[%0d] count=%0d pc=%h exp 2/%h", i, iq_count, ifu_exu_pc_d, 32'h300 + 32'(4 * i));
            else passes++;
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (ifu_exu_pc_d !== 32'h328 + 32'(4 * i))
                $display("FAIL b2b_tail[%0d] pc=%h exp %h", i, ifu_exu_pc_d, 32'h328 + 32'(4 * i));
            else passes++;
            tick();
        end
    endtask

    task automatic test_full_with_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 32'h410, 1'b0, 1'b0);
        checks++;
        if (iq_dec_ready !== 1'b0) $display("FAIL fullpop_ready ready=%0b exp 0", iq_dec_ready);
        else passes++;
        tick();
        checks++;
        if (iq_count !== CNT_W'(3) || ifu_exu_pc_d !== 32'h404)
            $display("FAIL fullpop_count count=%0d pc=%h exp 3/404", iq_count, ifu_exu_pc_d);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (ifu_exu_pc_d !== 32'h404 + 32'(4 * i))
                $display("FAIL fullpop_drain[%0d] pc=%h exp %h", i, ifu_exu_pc_d, 32'h404 + 32'(4 * i));
            else passes++;
            tick();
        end
        checks++;
        if (ifu_exu_valid_d !== 1'b0) $display("FAIL fullpop_refused_absent valid=%0b exp 0", ifu_exu_valid_d);
        else passes++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 32'h50c, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (iq_count !== '0 || ifu_exu_valid_d !== 1'b0 || iq_dec_ready !== 1'b1)
            $display("FAIL flush_state count=%0d valid=%0b ready=%0b exp 0/0/1", iq_count, ifu_exu_valid_d, iq_dec_ready);
        else passes++;
        drive(1'b1, 32'h200, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (ifu_exu_valid_d !== 1'b1 || ifu_exu_pc_d !== 32'h200 || iq_count !== CNT_W'(1))
            $display("FAIL flush_repush valid=%0b pc=%h count=%0d exp 1/200/1", ifu_exu_valid_d, ifu_exu_pc_d, iq_count);
        else passes++;
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h700 + 32'(4 * i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ifu_exu_valid_d !== 1'b0 || iq_count !== '0)
            $display("FAIL async_reset valid=%0b count=%0d exp 0/0", ifu_exu_valid_d, iq_count);
        else passes++;
        mq.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 32'h600, 1'b1, 1'b0, 1'b1, 6'h08);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (ifu_exu_valid_d !== 1'b1 || ifu_exu_pc_d !== 32'h600 || ifu_exu_exception_d !== 1'b1 || ifu_exu_exccode_d !== 6'h08)
            $display("FAIL async_exc_entry valid=%0b pc=%h exc=%0b code=%h exp 1/600/1/08",
                     ifu_exu_valid_d, ifu_exu_pc_d, ifu_exu_exception_d, ifu_exu_exccode_d);
        else passes++;
        tick();
        checks++;
        if (ifu_exu_valid_d !== 1'b0) $display("FAIL async_exc_popped valid=%0b exp 0", ifu_exu_valid_d);
        else passes++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, $urandom, ($urandom % 10) < 4, ($urandom % 25) == 0,
                  ($urandom % 8) == 0, 6'($urandom));
            checks++;
            if (iq_count !== CNT_W'(mq.size()) || iq_dec_ready !== (mq.size() != DEPTH) ||
                ifu_exu_valid_d !== (mq.size() != 0))
                $display("FAIL rand_ctrl[%0d] count=%0d ready=%0b valid=%0b exp count %0d", i, iq_count,
                         iq_dec_ready, ifu_exu_valid_d, mq.size());
            else passes++;
            checks++;
            if (dut_head() !== exp_head())
                $display("FAIL rand_head[%0d] got %h exp %h", i, dut_head(), exp_head());
            else passes++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_latency();
        test_back_to_back();
        test_full_with_pop();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
